// File: rtl/pmipsl_run_monitor.sv
// Run-control harness for PMIPSL cores: sequences processor reset, bounds the run,
// detects branch-to-self halt, keeps a circular PC trace and reports pass/fail.
module pmipsl_run_monitor #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 75,
  parameter int HALT_REPEAT  = 3,
  parameter int TRACE_DEPTH  = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                imemaddr,
  input  logic                             dmemwrite,
  input  logic [DATA_W-1:0]                probe,
  input  logic [DATA_W-1:0]                expect_probe,
  output logic                             cpu_reset,
  output logic                             running,
  output logic                             done,
  output logic                             halted,
  output logic                             timeout,
  output logic                             pass,
  output logic [15:0]                      cycle_count,
  output logic [15:0]                      write_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_rd_idx,
  output logic [ADDR_W-1:0]                trace_rd_pc,
  output logic [$clog2(TRACE_DEPTH):0]     trace_count
);

  localparam int PW  = $clog2(TRACE_DEPTH);
  localparam int SW  = $clog2(HALT_REPEAT + 1);
  localparam int RCW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RST_CPU, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [RCW-1:0]    rst_cnt;
  logic [SW-1:0]     same_cnt, same_nxt;
  logic [ADDR_W-1:0] prev_pc;
  logic [PW-1:0]     ptr, rd_ptr;
  logic [15:0]       cycle_inc;
  logic              halt_ev, timeout_ev, end_ev;
  logic [ADDR_W-1:0] trace_mem [TRACE_DEPTH];

  assign cpu_reset = (state != S_RUN);
  assign running   = (state == S_RUN);
  assign done      = (state == S_DONE);

  // cycle_count is cleared on start, so zero marks the first RUN cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cycle_inc = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
    same_nxt  = '0;
    if (cycle_count != 16'd0 && imemaddr == prev_pc)
      same_nxt = same_cnt + SW'(1);
    halt_ev    = (state == S_RUN) && (same_nxt == SW'(HALT_REPEAT));
    timeout_ev = (state == S_RUN) && (cycle_inc == 16'(MAX_CYCLES));
    end_ev     = halt_ev || timeout_ev;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RST_CPU;
      S_RST_CPU: if (rst_cnt == '0) state_nxt = S_RUN;
      S_RUN:     if (end_ev) state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_RST_CPU;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rst_cnt     <= '0;
      same_cnt    <= '0;
      prev_pc     <= '0;
      ptr         <= '0;
      trace_count <= '0;
      cycle_count <= '0;
      write_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      pass        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rst_cnt     <= RCW'(RESET_CYCLES - 1);
            same_cnt    <= '0;
            ptr         <= '0;
            trace_count <= '0;
            cycle_count <= '0;
            write_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
          end
        end
        S_RST_CPU: if (rst_cnt != '0) rst_cnt <= rst_cnt - RCW'(1);
        S_RUN: begin
          cycle_count <= cycle_inc;
          if (dmemwrite && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
          prev_pc  <= imemaddr;
          same_cnt <= same_nxt;
          ptr      <= ptr + PW'(1);
          if (trace_count != (PW+1)'(TRACE_DEPTH)) trace_count <= trace_count + (PW+1)'(1);
          // Halt wins a tie with the budget.
          if (end_ev) begin
            halted  <= halt_ev;
            timeout <= timeout_ev && !halt_ev;
            pass    <= halt_ev && (probe == expect_probe);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: trace storage is not reset; trace_count gates which entries are visible.
  always_ff @(posedge clock) begin
    if (reset && state == S_RUN) trace_mem[ptr] <= imemaddr;
  end

  always_comb begin
    rd_ptr      = ptr - PW'(1) - trace_rd_idx;
    trace_rd_pc = '0;
    if ({1'b0, trace_rd_idx} < trace_count) trace_rd_pc = trace_mem[rd_ptr];
  end

endmodule

// File: tb/tb_pmipsl_run_monitor.sv
// Directed bench for pmipsl_run_monitor: reset, halt/pass/fail, timeout, tie, trace, abort.
module tb_pmipsl_run_monitor;

  logic        clock = 1'b0;
  logic        reset, start, dmemwrite;
  logic [15:0] imemaddr, probe, expect_probe;
  logic [2:0]  trace_rd_idx;

  logic        cpu_reset, running, done, halted, timeout, pass;
  logic [15:0] cycle_count, write_count, trace_rd_pc;
  logic [3:0]  trace_count;

  logic        cpu_reset7, running7, done7, halted7, timeout7, pass7;
  logic [15:0] cycle_count7, write_count7, trace_rd_pc7;
  logic [3:0]  trace_count7;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pmipsl_run_monitor dut (
    .clock(clock), .reset(reset), .start(start), .imemaddr(imemaddr),
    .dmemwrite(dmemwrite), .probe(probe), .expect_probe(expect_probe),
    .cpu_reset(cpu_reset), .running(running), .done(done), .halted(halted),
    .timeout(timeout), .pass(pass), .cycle_count(cycle_count),
    .write_count(write_count), .trace_rd_idx(trace_rd_idx),
    .trace_rd_pc(trace_rd_pc), .trace_count(trace_count)
  );

  pmipsl_run_monitor #(.MAX_CYCLES(7)) dut7 (
    .clock(clock), .reset(reset), .start(start), .imemaddr(imemaddr),
    .dmemwrite(dmemwrite), .probe(probe), .expect_probe(expect_probe),
    .cpu_reset(cpu_reset7), .running(running7), .done(done7), .halted(halted7),
    .timeout(timeout7), .pass(pass7), .cycle_count(cycle_count7),
    .write_count(write_count7), .trace_rd_idx(trace_rd_idx),
    .trace_rd_pc(trace_rd_pc7), .trace_count(trace_count7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic feed(input logic [15:0] pc, input logic wr);
    imemaddr  = pc;
    dmemwrite = wr;
    step();
  endtask

  // Start pulse, then cpu_reset must stay high for exactly two cycles.
  task automatic run_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_rst1_cpu_reset"}, cpu_reset, 1);
    check({tag, "_rst1_flags"}, {done, halted, timeout, pass, running}, 0);
    check({tag, "_rst1_cycles"}, cycle_count, 0);
    step();
    check({tag, "_rst2_cpu_reset"}, cpu_reset, 1);
    step();
    check({tag, "_run_running"}, running, 1);
    check({tag, "_run_cpu_reset"}, cpu_reset, 0);
  endtask

  logic [15:0] halt_pcs [7] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd6, 16'd6, 16'd6};
  logic        halt_wr  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1'b0; start = 1'b0; dmemwrite = 1'b0; imemaddr = '0;
    probe = '0; expect_probe = '0; trace_rd_idx = '0;

    // Reset held two cycles
    step(); step();
    check("reset_cpu_reset", cpu_reset, 1);
    check("reset_flags", {done, running, halted, timeout, pass}, 0);
    check("reset_counts", {cycle_count, write_count}, 0);
    check("reset_trace_count", trace_count, 0);
    reset = 1'b1;
    step();
    check("idle_cpu_reset", cpu_reset, 1);

    // Halt with matching probe; three writes; MAX_CYCLES=7 instance ties
    probe = 16'd5; expect_probe = 16'd5;
    run_start("halt");
    for (int i = 0; i < 6; i++) feed(halt_pcs[i], halt_wr[i]);
    check("halt_not_done_yet", done, 0);
    feed(halt_pcs[6], halt_wr[6]);
    check("halt_done", done, 1);
    check("halt_halted", halted, 1);
    check("halt_pass", pass, 1);
    check("halt_timeout", timeout, 0);
    check("halt_cycle_count", cycle_count, 7);
    check("halt_write_count", write_count, 3);
    check("halt_cpu_reset", {cpu_reset, running}, 2'b10);
    check("tie_halted", halted7, 1);
    check("tie_timeout", timeout7, 0);
    check("tie_write_count", write_count7, 3);
    check("halt_trace_count", trace_count, 7);
    trace_rd_idx = 3'd0; #1 check("halt_trace_idx0", trace_rd_pc, 6);
    trace_rd_idx = 3'd4; #1 check("halt_trace_idx4", trace_rd_pc, 4);
    trace_rd_idx = 3'd6; #1 check("halt_trace_idx6", trace_rd_pc, 0);
    trace_rd_idx = 3'd7; #1 check("halt_trace_idx7_invalid", trace_rd_pc, 0);
    feed(16'd40, 1'b1);
    check("done_frozen_cycles", cycle_count, 7);
    check("done_frozen_writes", write_count, 3);
    check("done_frozen_flags", {done, halted, pass}, 3'b111);

    // Same halt, probe mismatch; restart from DONE
    probe = 16'd4; expect_probe = 16'd5;
    run_start("fail");
    for (int i = 0; i < 7; i++) feed(halt_pcs[i], 1'b0);
    check("fail_done", done, 1);
    check("fail_halted", halted, 1);
    check("fail_pass", pass, 0);
    check("fail_write_count", write_count, 0);

    // Incrementing PC until the 75-cycle budget runs out
    probe = 16'd5; expect_probe = 16'd5;
    run_start("tmo");
    for (int i = 0; i < 74; i++) feed(16'(2 * i), 1'b0);
    check("tmo_not_done_yet", done, 0);
    feed(16'd148, 1'b0);
    check("tmo_done", done, 1);
    check("tmo_timeout", timeout, 1);
    check("tmo_halted", halted, 0);
    check("tmo_pass", pass, 0);
    check("tmo_cycle_count", cycle_count, 75);
    check("tmo_trace_count", trace_count, 8);
    trace_rd_idx = 3'd0; #1 check("tmo_trace_idx0", trace_rd_pc, 148);
    trace_rd_idx = 3'd7; #1 check("tmo_trace_idx7", trace_rd_pc, 134);

    // Trace wrap over 12 PCs, then abort with reset mid-run
    run_start("trace");
    for (int i = 0; i < 12; i++) feed(16'(2 * i), 1'b0);
    check("trace_running", running, 1);
    check("trace_cycle_count", cycle_count, 12);
    check("trace_count_sat", trace_count, 8);
    trace_rd_idx = 3'd0; #1 check("trace_idx0", trace_rd_pc, 22);
    trace_rd_idx = 3'd5; #1 check("trace_idx5", trace_rd_pc, 12);
    trace_rd_idx = 3'd7; #1 check("trace_idx7", trace_rd_pc, 8);
    reset = 1'b0;
    step();
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_flags", {done, running, halted, timeout, pass}, 0);
    check("abort_counts", {cycle_count, write_count}, 0);
    check("abort_trace_count", trace_count, 0);
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
